// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and skid buffer; optional FETCH_HALT_EN halts fetch on opcode 4'hF
module fetch_stage #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [3:0]         if_opcode
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic               drop_q, drop_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               halted;

    logic               req_allowed;
    logic               accept;
    logic               consume;

    // A request is only presented in REQ when the skid is empty and fetch is not halted
    always_comb begin
        req_allowed = (state_q == ST_REQ) && !skid_valid_q && !halted;
        // A response is usable only in WAIT, when it is not being flushed
        accept      = (state_q == ST_WAIT) && imem_rvalid && !drop_q && !redirect_valid;
        consume     = if_valid_q && !stall;
    end

    assign imem_req  = req_allowed;
    assign imem_addr = req_allowed ? pc_q : '0;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_opcode = if_instr_q[INSTR_W-1 -: 4];

    // Next-state for FSM, PC, drop flag, output register and skid buffer
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect_valid) begin
            // Redirect flushes everything younger and overrides stall
            pc_d         = redirect_pc;
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (req_allowed && imem_gnt) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (req_allowed && imem_gnt) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_W'(1);
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (consume) begin
                // Refill after a transfer: skid first, then a same-cycle response
                if (skid_valid_q) begin
                    if_instr_d   = skid_instr_q;
                    if_pc_d      = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    if_instr_d   = imem_rdata;
                    if_pc_d      = req_pc_q;
                end else begin
                    if_valid_d   = 1'b0;
                end
            end else if (!if_valid_q) begin
                if (accept) begin
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata;
                    if_pc_d    = req_pc_q;
                end
            end else if (accept) begin
                // Output held by stall: park the response in the skid
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = req_pc_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC_V;
            req_pc_q     <= '0;
            drop_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q, halted_d;

    // Halt once a 4'hF opcode is newly loaded into the output register; redirect resumes
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (if_valid_d && !(if_valid_q && stall) &&
                     (if_instr_d[INSTR_W-1 -: 4] == 4'hF)) begin
            halted_d = 1'b1;
        end
    end

    // Halted flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with memory responder and program-order model
module tb_fetch_stage;

    localparam logic [7:0] RST_PC = 8'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic [3:0]  if_opcode;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode)
    );

    int          n_pass = 0;
    int          n_checks = 0;
    logic [15:0] mem [256];
    bit          pend = 0;
    logic [7:0]  pend_addr = 0;
    int          lat = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          gnt_pct = 100;
    int          spur_pct = 0;
    logic [7:0]  exp_pc = RST_PC;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive memory side, check transfers against program order, advance
    task automatic cycle();
        bit          resp, granted, hold, flush;
        logic [7:0]  g_addr, h_pc;
        logic [15:0] h_instr;
        resp = pend && (lat == 0);
        if (resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[pend_addr];
        end else begin
            imem_rvalid = !pend && ($urandom_range(99) < spur_pct);
            imem_rdata  = 16'($urandom);
            if (pend) lat--;
        end
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (imem_req) check("one_outstanding", 32'(pend), 0);
        granted = imem_req && imem_gnt;
        g_addr  = imem_addr;
        hold    = if_valid && stall && !redirect_valid;
        h_pc    = if_pc;
        h_instr = if_instr;
        flush   = redirect_valid;
        if (redirect_valid) begin
            exp_pc = redirect_pc;
        end else if (if_valid && !stall) begin
            check("xfer_pc", if_pc, exp_pc);
            check("xfer_instr", if_instr, mem[exp_pc]);
            check("xfer_opcode", if_opcode, mem[exp_pc][15:12]);
            exp_pc = exp_pc + 8'd1;
        end
        @(posedge clk);
        #1;
        if (resp) pend = 0;
        if (granted) begin
            pend      = 1;
            pend_addr = g_addr;
            lat       = $urandom_range(lat_max, lat_min);
        end
        if (flush) check("flush_valid", if_valid, 0);
        if (hold) begin
            check("hold_valid", if_valid, 1);
            check("hold_pc", if_pc, h_pc);
            check("hold_instr", if_instr, h_instr);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 50) begin
            cycle();
            n++;
        end
        check({tag, "_req_seen"}, imem_req, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 50) begin
            cycle();
            n++;
        end
        check({tag, "_valid_seen"}, if_valid, 1);
    endtask

    task automatic do_redirect(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        int reqs;
        for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(14)), 12'($urandom)};
        mem[8'h10] = 16'h7123;
        stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 0);
        check("rst_pc", if_pc, 0);
        rst_n = 1'b1;

        // First fetch from RESET_PC
        wait_req("first");
        check("first_addr", imem_addr, 8'h10);
        wait_valid("first");
        check("first_if_pc", if_pc, 8'h10);
        check("first_opcode", if_opcode, 4'h7);
        check("first_instr", if_instr, 16'h7123);
        check("next_req", imem_req, 1);
        check("next_addr", imem_addr, 8'h11);

        // Stall five cycles: output held, next response parked, request held off
        stall = 1'b1;
        repeat (5) cycle();
        check("stall_pc", if_pc, 8'h10);
        check("stall_instr", if_instr, 16'h7123);
        check("skid_full_noreq", imem_req, 0);
        stall = 1'b0;
        cycle();
        check("skid_out_valid", if_valid, 1);
        check("skid_out_pc", if_pc, 8'h11);
        check("skid_out_instr", if_instr, mem[8'h11]);
        repeat (6) cycle();

        // Redirect in WAIT before the response
        lat_min = 2; lat_max = 2;
        n = 0;
        while (!(pend && lat > 0) && n < 50) begin cycle(); n++; end
        check("wait_pend_seen", 32'(pend && lat > 0), 1);
        do_redirect(8'h40);
        wait_req("redir40");
        check("redir40_addr", imem_addr, 8'h40);
        repeat (8) cycle();

        // Redirect in the same cycle as the response
        lat_min = 0; lat_max = 0;
        n = 0;
        while (!(pend && lat == 0) && n < 50) begin cycle(); n++; end
        check("resp_pend_seen", 32'(pend && lat == 0), 1);
        do_redirect(8'h60);
        wait_req("redir60");
        check("redir60_addr", imem_addr, 8'h60);
        repeat (8) cycle();

        // PC wrap 0xFF -> 0x00
        do_redirect(8'hFE);
        n = 0;
        while (!(imem_req && imem_addr == 8'hFF) && n < 50) begin cycle(); n++; end
        check("ff_req_seen", 32'(imem_req && imem_addr == 8'hFF), 1);
        cycle();
        wait_req("wrap");
        check("wrap_addr", imem_addr, 8'h00);
        repeat (6) cycle();

        // HALT opcode at 0x05
        mem[8'h05] = 16'hF000;
        do_redirect(8'h05);
        wait_valid("halt");
        check("halt_pc", if_pc, 8'h05);
        check("halt_opcode", if_opcode, 4'hF);
`ifdef FETCH_HALT_EN
        reqs = 0;
        repeat (10) begin
            if (imem_req) reqs++;
            cycle();
        end
        check("halt_no_req", reqs, 0);
        check("halt_drained", if_valid, 0);
        mem[8'h05] = 16'h0005;
        do_redirect(8'h20);
        wait_req("resume");
        check("resume_addr", imem_addr, 8'h20);
`else
        reqs = 0;
        wait_req("nohalt");
        check("nohalt_addr", imem_addr, 8'h06);
        cycle();
        mem[8'h05] = 16'h0005;
`endif
        repeat (6) cycle();

        // Randomized traffic with a mid-run asynchronous reset
        gnt_pct = 70; lat_min = 0; lat_max = 3; spur_pct = 20;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) begin
                imem_rvalid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_valid", if_valid, 0);
                check("mid_rst_req", imem_req, 0);
                check("mid_rst_pc", if_pc, 0);
                pend = 0;
                exp_pc = RST_PC;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            stall          = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc    = 8'($urandom);
            cycle();
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
